multi_voice_synth: RTL

- Parametrised successor to the fixed three-voice tone generator.
- NUM_VOICES independent oscillators, each with its own runtime-selectable waveform (square, sawtooth, triangle, sine), period and enable.
- All voices run on one 32-step phase scheme.
- Enabled voices are summed, without loss, into one registered sample that feeds the DAC output path; the SPI command decoder drives it through a single-cycle configuration write port.

---
 rtl/synth_pkg.sv | 35 +++
 rtl/multi_voice_synth_if.sv | 22 ++
 rtl/voice_osc.sv | 86 ++++++++
 rtl/multi_voice_synth.sv | 64 ++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the multi-voice tone generator.
// Waveform select, sample/phase widths, sine table and per-phase sample lookup.
package synth_pkg;

  typedef enum logic [1:0] {
    SQUARE = 2'd0,
    SAW    = 2'd1,
    TRI    = 2'd2,
    SINE   = 2'd3
  } wave_t;

  localparam int unsigned SAMPLE_W = 4;
  localparam int unsigned PHASE_W  = 5;

  localparam logic [SAMPLE_W-1:0] SINE_LUT [32] = '{
    4'd8,  4'd9,  4'd10, 4'd12, 4'd13, 4'd14, 4'd14, 4'd15,
    4'd15, 4'd15, 4'd14, 4'd14, 4'd13, 4'd12, 4'd10, 4'd9,
    4'd8,  4'd6,  4'd5,  4'd3,  4'd2,  4'd1,  4'd1,  4'd0,
    4'd0,  4'd0,  4'd1,  4'd1,  4'd2,  4'd3,  4'd5,  4'd6
  };

  function automatic logic [SAMPLE_W-1:0] wave_sample(input wave_t wave,
                                                      input logic [PHASE_W-1:0] p);
    logic [SAMPLE_W-1:0] s;
    s = '0;
    unique case (wave)
      SQUARE: s = p[4] ? 4'd15 : 4'd0;
      SAW:    s = p[4:1];
      TRI:    s = p[4] ? (4'd15 - p[3:0]) : p[3:0];
      SINE:   s = SINE_LUT[p];
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multi_voice_synth_if.sv
// Single-cycle configuration write port from the SPI command decoder to the synth.
interface multi_voice_synth_if #(
    parameter int unsigned PRD_W  = 32,
    parameter int unsigned VIDX_W = 2
);
    import synth_pkg::*;

    logic              cfg_valid;
    logic [VIDX_W-1:0] cfg_voice;
    logic              cfg_enable;
    wave_t             cfg_wave;
    logic [PRD_W-1:0]  cfg_period;

    modport master (
        output cfg_valid, cfg_voice, cfg_enable, cfg_wave, cfg_period
    );

    modport slave (
        input cfg_valid, cfg_voice, cfg_enable, cfg_wave, cfg_period
    );

endinterface

// File: rtl/voice_osc.sv
// One oscillator voice: config registers, step counter / 32-step phase FSM,
// registered wrap pulse and combinational waveform lookup.
module voice_osc
    import synth_pkg::*;
#(
    parameter int unsigned PRD_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr,
    input  logic                enable,
    input  wave_t               wave,
    input  logic [PRD_W-1:0]    period,
    output logic [SAMPLE_W-1:0] sample,
    output logic                active,
    output logic                wrap
);

    localparam int unsigned STEP_W = PRD_W - 5;

    typedef enum logic {
        StIdle,
        StRun
    } state_t;

    state_t              state_q;
    logic                en_q;
    wave_t               wave_q;
    logic [STEP_W-1:0]   len_q;
    logic [STEP_W-1:0]   cnt_q;
    logic [PHASE_W-1:0]  phase_q;
    logic                wrap_q;

    // Effective period is 32*L cycles; the five LSBs of the period are dropped.
    logic [STEP_W-1:0] new_len;
    logic              unused_period_lsb;
    assign new_len           = period[PRD_W-1:5];
    assign unused_period_lsb = ^period[4:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            en_q    <= 1'b0;
            wave_q  <= SQUARE;
            len_q   <= '0;
            cnt_q   <= '0;
            phase_q <= '0;
            wrap_q  <= 1'b0;
        end else if (wr) begin
            // A write always restarts the voice in phase and suppresses the wrap pulse.
            en_q    <= enable;
            wave_q  <= wave;
            len_q   <= new_len;
            cnt_q   <= '0;
            phase_q <= '0;
            wrap_q  <= 1'b0;
            state_q <= (enable && (new_len != '0)) ? StRun : StIdle;
        end else begin
            wrap_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q   <= '0;
                    phase_q <= '0;
                end
                StRun: begin
                    if (!en_q || (len_q == '0)) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        phase_q <= '0;
                    end else if (cnt_q == (len_q - STEP_W'(1))) begin
                        cnt_q   <= '0;
                        phase_q <= phase_q + PHASE_W'(1);
                        wrap_q  <= (phase_q == '1);
                    end else begin
                        cnt_q <= cnt_q + STEP_W'(1);
                    end
                end
            endcase
        end
    end

    assign active = (state_q == StRun);
    assign wrap   = wrap_q;
    assign sample = active ? wave_sample(wave_q, phase_q) : '0;

endmodule

// File: rtl/multi_voice_synth.sv
// NUM_VOICES independent oscillators with per-voice config decode and a
// registered lossless mixer feeding the DAC path.
module multi_voice_synth
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned PRD_W      = 32,
    parameter int unsigned VIDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    localparam int unsigned OUT_W     = SAMPLE_W + $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    multi_voice_synth_if.slave    cfg,
    output logic [OUT_W-1:0]      mix_out,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic [NUM_VOICES-1:0] phase_wrap
);

    logic [SAMPLE_W-1:0]   samples [NUM_VOICES];
    logic [NUM_VOICES-1:0] wr;
    logic [NUM_VOICES-1:0] active;
    logic [NUM_VOICES-1:0] wrap;

    // Out-of-range indices match no voice, so such writes are dropped.
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        assign wr[i] = cfg.cfg_valid && (cfg.cfg_voice == VIDX_W'(i));

        voice_osc #(
            .PRD_W (PRD_W)
        ) u_voice (
            .clk     (clk),
            .reset_n (reset_n),
            .wr      (wr[i]),
            .enable  (cfg.cfg_enable),
            .wave    (cfg.cfg_wave),
            .period  (cfg.cfg_period),
            .sample  (samples[i]),
            .active  (active[i]),
            .wrap    (wrap[i])
        );
    end

    logic [OUT_W-1:0] mix_d;

    // Idle voices already present a zero sample.
    always_comb begin
        mix_d = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            mix_d = mix_d + OUT_W'(samples[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mix_out <= '0;
        end else begin
            mix_out <= mix_d;
        end
    end

    assign voice_active = active;
    assign phase_wrap   = wrap;

endmodule
